// File: rtl/data_memory_lsu.sv
// data_memory_lsu: RV32I data memory with byte-lane stores, extended loads, fault detection and post-reset clear
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        WE,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] RD,
    output logic        fault
);
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_n;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];
    logic acc, flt, bad_f3, mis, oor, wr;
    logic [AW-1:0] widx;
    logic [3:0] be;
    logic [31:0] wd_rep, rword, sh, ld;

    // leave CLEAR once the last word has been zeroed; accept requests only in READY
    always_comb begin
        state_n = (state == CLEAR && idx == AW'(DEPTH_WORDS - 1)) ? READY : state;
        ready = state == READY;
    end

    // decode the access: legality, byte lanes, replicated store data and extended load data
    always_comb begin
        acc = req && ready;
        bad_f3 = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (WE && funct3[2]);
        mis = (funct3[1:0] == 2'b01 && A[0]) || (funct3[1:0] == 2'b10 && A[1:0] != 2'b00);
        oor = (A >> (AW + 2)) != 32'd0;
        flt = bad_f3 || mis || oor;
        wr = acc && WE && !flt;
        widx = A[AW+1:2];
        be = funct3[1:0] == 2'b00 ? 4'b0001 << A[1:0] :
             funct3[1:0] == 2'b01 ? (A[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_rep = funct3[1:0] == 2'b00 ? {4{WD[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{WD[15:0]}} : WD;
        rword = mem[widx];
        sh = rword >> {A[1:0], 3'b000};
        ld = funct3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
             funct3 == 3'b100 ? {24'b0, sh[7:0]} :
             funct3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
             funct3 == 3'b101 ? {16'b0, sh[15:0]} : rword;
    end

    // zero one word per cycle while clearing, otherwise apply masked stores
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[idx] <= '0;
        else if (wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wd_rep[8*b +: 8];
    end

    // FSM state and clear index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            idx <= '0;
        end else begin
            state <= state_n;
            if (state == CLEAR) idx <= idx + AW'(1);
        end
    end

    // registered response pulse; RD is zero unless a legal load completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            fault <= 1'b0;
            RD <= '0;
        end else begin
            resp_valid <= acc;
            fault <= acc && flt;
            RD <= (acc && !WE && !flt) ? ld : '0;
        end
    end
endmodule
